// File: rtl/clkspec_v2arbtst_server.sv
// Two-client multiply server: one pending job slot per client, round-robin grant,
// shift-add multiply on a shared datapath, result returned with a one-cycle ack.
module clkspec_v2arbtst_server #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [WIDTH-1:0] y0,
  output logic             ack0,
  output logic [WIDTH-1:0] y1,
  output logic             ack1,
  output logic             busy0,
  output logic             busy1,
  output logic             err0,
  output logic             err1
);

  // state | meaning
  // IDLE  | waiting for a pending slot, grants round-robin
  // CALC  | one shift-add iteration per cycle, WIDTH iterations
  // DONE  | deliver result to owner, release its slot
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]       state;
  logic             pend0, pend1;
  logic [WIDTH-1:0] slot_a0, slot_b0, slot_a1, slot_b1;
  logic             owner;
  logic             rr_last;
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [CW-1:0]    count;

  logic grant_valid;
  logic grant_id;
  logic done0, done1;

  // rr_last holds the last served client; on a tie the other one wins
  always_comb begin
    grant_valid = pend0 | pend1;
    grant_id    = (pend0 && pend1) ? ~rr_last : pend1;
    done0       = (state == ST_DONE) && (owner == 1'b0);
    done1       = (state == ST_DONE) && (owner == 1'b1);
  end

  // A capture in the release cycle keeps the slot occupied without an error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend0   <= 1'b0;
      slot_a0 <= '0;
      slot_b0 <= '0;
      err0    <= 1'b0;
    end else begin
      if (req0 && (!pend0 || done0)) begin
        slot_a0 <= a0;
        slot_b0 <= b0;
        pend0   <= 1'b1;
      end else if (done0) begin
        pend0   <= 1'b0;
      end
      if (req0 && pend0 && !done0)
        err0 <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend1   <= 1'b0;
      slot_a1 <= '0;
      slot_b1 <= '0;
      err1    <= 1'b0;
    end else begin
      if (req1 && (!pend1 || done1)) begin
        slot_a1 <= a1;
        slot_b1 <= b1;
        pend1   <= 1'b1;
      end else if (done1) begin
        pend1   <= 1'b0;
      end
      if (req1 && pend1 && !done1)
        err1 <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      owner   <= 1'b0;
      rr_last <= 1'b1;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            owner   <= grant_id;
            rr_last <= grant_id;
            mcand   <= grant_id ? slot_a1 : slot_a0;
            mplier  <= grant_id ? slot_b1 : slot_b0;
            acc     <= '0;
            count   <= '0;
            state   <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (mplier[0])
            acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CNT_ONE;
          if (count == CNT_LAST)
            state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y0   <= '0;
      y1   <= '0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
    end else begin
      ack0 <= done0;
      ack1 <= done1;
      if (done0) y0 <= acc;
      if (done1) y1 <= acc;
    end
  end

  assign busy0 = pend0;
  assign busy1 = pend1;

endmodule
